// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm clock sequencing controller.
package alarm_pkg;

    typedef enum logic [2:0] {
        SHOW_TIME,
        KEY_ENTRY,
        KEY_STORED,
        KEY_WAITED,
        SHOW_ALARM,
        SET_ALARM_TIME,
        SET_CURRENT_TIME
    } state_t;

    // Keypad code meaning "no key pressed"; 11..15 behave the same way.
    localparam logic [3:0] NOKEY = 4'd10;

    // True only for the decimal digit codes 0..9.
    function automatic logic key_is_digit(input logic [3:0] k);
        return (k <= 4'd9);
    endfunction

endpackage

// File: rtl/alarm_fsm_ctrl_if.sv
// Keypad/button inputs and register-control commands of the alarm controller.
interface alarm_fsm_ctrl_if;
    logic       one_second;
    logic [3:0] key;
    logic       alarm_button;
    logic       time_button;
    logic       reset_count;
    logic       load_new_c;
    logic       load_new_a;
    logic       show_a;
    logic       show_new_time;
    logic       shift;

    // Environment side: drives keypad, buttons and the seconds pulse.
    modport master (
        output one_second, key, alarm_button, time_button,
        input  reset_count, load_new_c, load_new_a, show_a, show_new_time, shift
    );

    // Controller side: consumes inputs, issues commands.
    modport slave (
        input  one_second, key, alarm_button, time_button,
        output reset_count, load_new_c, load_new_a, show_a, show_new_time, shift
    );
endinterface

// File: rtl/alarm_fsm_ctrl_sva.sv
// Protocol assertions for the alarm sequencer, attached to every instance.
module alarm_fsm_ctrl_sva
    import alarm_pkg::*;
(
    input logic   clock,
    input logic   reset,
    input state_t state_q,
    input logic   shift_cmd,
    input logic   load_a_cmd,
    input logic   load_c_cmd,
    input logic   reset_count_cmd
);

    // Register commands never overlap.
    a_cmd_onehot: assert property (@(posedge clock) disable iff (reset)
        $onehot0({load_a_cmd, load_c_cmd, shift_cmd}));

    // The prescaler restart always accompanies a current-time load.
    a_reset_count_tracks_load: assert property (@(posedge clock) disable iff (reset)
        reset_count_cmd == load_c_cmd);

    // A stored key is shifted exactly once.
    a_key_stored_one_cycle: assert property (@(posedge clock) disable iff (reset)
        (state_q == KEY_STORED) |=> (state_q != KEY_STORED));

endmodule

bind alarm_fsm_ctrl alarm_fsm_ctrl_sva u_sva (
    .clock           (clock),
    .reset           (reset),
    .state_q         (state_q),
    .shift_cmd       (shift_cmd),
    .load_a_cmd      (load_a_cmd),
    .load_c_cmd      (load_c_cmd),
    .reset_count_cmd (reset_count_cmd)
);

// File: rtl/alarm_timeout_timer.sv
// Saturating count of one_second pulses used to abandon a stalled key entry.
module alarm_timeout_timer #(
    parameter int TIMEOUT_SEC = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic one_second,
    output logic timeout
);

    localparam int TW = $clog2(TIMEOUT_SEC + 1);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_SEC);

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    // Clear has priority; otherwise count pulses and hold at the limit.
    always_comb begin
        timer_d = timer_q;
        if (clear) begin
            timer_d = '0;
        end else if (one_second && (timer_q != LIMIT)) begin
            timer_d = timer_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    // Evaluated on the registered count, so the exit lags the last pulse by a cycle.
    assign timeout = (timer_q == LIMIT);

endmodule

// File: rtl/alarm_fsm_ctrl.sv
// Alarm clock sequencer: turns keypad/button activity into register commands.
module alarm_fsm_ctrl
    import alarm_pkg::*;
#(
    parameter int TIMEOUT_SEC = 10
) (
    input  logic              clock,
    input  logic              reset,
    alarm_fsm_ctrl_if.slave   bus
);

    state_t state_q;
    state_t state_d;

    logic timeout;
    logic timer_clear;
    logic in_window_q;
    logic in_window_d;

    logic reset_count_cmd;
    logic load_c_cmd;
    logic load_a_cmd;
    logic show_a_cmd;
    logic show_new_cmd;
    logic shift_cmd;

    // State register; reset forces SHOW_TIME without waiting for a clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= SHOW_TIME;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; buttons outrank digits, and digits outrank timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SHOW_TIME: begin
                if (bus.alarm_button)           state_d = SHOW_ALARM;
                else if (key_is_digit(bus.key)) state_d = KEY_STORED;
            end
            KEY_STORED: begin
                state_d = KEY_WAITED;
            end
            KEY_WAITED: begin
                if (!key_is_digit(bus.key))     state_d = KEY_ENTRY;
                else if (timeout)               state_d = SHOW_TIME;
            end
            KEY_ENTRY: begin
                if (bus.alarm_button)           state_d = SET_ALARM_TIME;
                else if (bus.time_button)       state_d = SET_CURRENT_TIME;
                else if (key_is_digit(bus.key)) state_d = KEY_STORED;
                else if (timeout)               state_d = SHOW_TIME;
            end
            SHOW_ALARM: begin
                if (!bus.alarm_button)          state_d = SHOW_TIME;
            end
            SET_ALARM_TIME:   state_d = SHOW_TIME;
            SET_CURRENT_TIME: state_d = SHOW_TIME;
            default:          state_d = SHOW_TIME;
        endcase
    end

    // The timer only runs while staying inside the waiting states; leaving them
    // (including toward KEY_STORED) clears it, so a coincident pulse is dropped.
    always_comb begin
        in_window_q = (state_q == KEY_WAITED) || (state_q == KEY_ENTRY);
        in_window_d = (state_d == KEY_WAITED) || (state_d == KEY_ENTRY);
        timer_clear = !(in_window_q && in_window_d);
    end

    alarm_timeout_timer #(
        .TIMEOUT_SEC (TIMEOUT_SEC)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .clear      (timer_clear),
        .one_second (bus.one_second),
        .timeout    (timeout)
    );

    // Moore output decode from the state register only.
    always_comb begin
        reset_count_cmd = 1'b0;
        load_c_cmd      = 1'b0;
        load_a_cmd      = 1'b0;
        show_a_cmd      = 1'b0;
        show_new_cmd    = 1'b0;
        shift_cmd       = 1'b0;
        case (state_q)
            KEY_STORED: begin
                shift_cmd    = 1'b1;
                show_new_cmd = 1'b1;
            end
            KEY_WAITED:       show_new_cmd = 1'b1;
            KEY_ENTRY:        show_new_cmd = 1'b1;
            SHOW_ALARM:       show_a_cmd   = 1'b1;
            SET_ALARM_TIME:   load_a_cmd   = 1'b1;
            SET_CURRENT_TIME: begin
                load_c_cmd      = 1'b1;
                reset_count_cmd = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.reset_count   = reset_count_cmd;
    assign bus.load_new_c    = load_c_cmd;
    assign bus.load_new_a    = load_a_cmd;
    assign bus.show_a        = show_a_cmd;
    assign bus.show_new_time = show_new_cmd;
    assign bus.shift         = shift_cmd;

endmodule

// File: tb/tb_alarm_fsm_ctrl.sv
// Directed bench for the alarm sequencer; outputs packed as
// {reset_count, load_new_c, load_new_a, show_a, show_new_time, shift}.
module tb_alarm_fsm_ctrl;
    import alarm_pkg::*;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    alarm_fsm_ctrl_if bus ();

    alarm_fsm_ctrl #(.TIMEOUT_SEC(10)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [5:0] outs();
        return {bus.reset_count, bus.load_new_c, bus.load_new_a,
                bus.show_a, bus.show_new_time, bus.shift};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.one_second   = 1'b0;
        bus.key          = NOKEY;
        bus.alarm_button = 1'b0;
        bus.time_button  = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #2;
        total++;
        if (outs() !== 6'b000000) begin
            bad++; $display("FAIL reset_outs got=%b exp=%b", outs(), 6'b000000);
        end
        total++;
        if (dut.u_timer.timer_q !== 4'd0) begin
            bad++; $display("FAIL reset_timer got=%0d exp=0", dut.u_timer.timer_q);
        end
        @(negedge clock);
        reset = 1'b0;
        tick();
        // walk into KEY_ENTRY and let the timer advance once
        bus.key = 4'd2;   tick();
        bus.key = NOKEY;  tick();
        tick();
        bus.one_second = 1'b1; tick();
        bus.one_second = 1'b0;
        total++;
        if (outs() !== 6'b000010 || dut.u_timer.timer_q !== 4'd1) begin
            bad++; $display("FAIL pre_reset_entry got=%b/%0d exp=%b/1", outs(), dut.u_timer.timer_q, 6'b000010);
        end
        #3 reset = 1'b1;
        #1;
        total++;
        if (outs() !== 6'b000000 || dut.state_q !== SHOW_TIME || dut.u_timer.timer_q !== 4'd0) begin
            bad++; $display("FAIL async_reset got=%b st=%0d tmr=%0d exp=000000 st=0 tmr=0",
                            outs(), dut.state_q, dut.u_timer.timer_q);
        end
        #1 reset = 1'b0;
        tick();
        total++;
        if (outs() !== 6'b000000 || dut.state_q !== SHOW_TIME) begin
            bad++; $display("FAIL after_release got=%b st=%0d exp=000000 st=0", outs(), dut.state_q);
        end
        $display("reset: async reset mid KEY_ENTRY checked");
    endtask

    task automatic test_shift_sequence();
        logic [3:0] keys [6];
        logic [5:0] exps [6];
        int shifts;
        keys = '{4'd3, 4'd3, NOKEY, 4'd7, NOKEY, NOKEY};
        exps = '{6'b000011, 6'b000010, 6'b000010, 6'b000011, 6'b000010, 6'b000010};
        shifts = 0;
        for (int i = 0; i < 6; i++) begin
            bus.key = keys[i];
            tick();
            shifts += int'(bus.shift);
            total++;
            if (outs() !== exps[i]) begin
                bad++; $display("FAIL shift_seq[%0d] got=%b exp=%b", i, outs(), exps[i]);
            end
        end
        total++;
        if (shifts != 2) begin
            bad++; $display("FAIL shift_count got=%0d exp=2", shifts);
        end
        $display("shift: two digits entered, shift pulses=%0d", shifts);
    endtask

    task automatic test_set_current_time();
        // continues from KEY_ENTRY with two digits entered
        bus.time_button = 1'b1;
        tick();
        bus.time_button = 1'b0;
        total++;
        if (outs() !== 6'b110000) begin
            bad++; $display("FAIL set_time_pulse got=%b exp=%b", outs(), 6'b110000);
        end
        tick();
        total++;
        if (outs() !== 6'b000000 || dut.state_q !== SHOW_TIME) begin
            bad++; $display("FAIL set_time_done got=%b exp=%b", outs(), 6'b000000);
        end
        $display("set_time: load_new_c/reset_count single pulse checked");
    endtask

    task automatic test_timeout();
        logic stray;
        stray = 1'b0;
        bus.key = 4'd1; tick();
        bus.key = NOKEY; tick();
        tick();
        for (int p = 1; p <= 10; p++) begin
            repeat (255) begin
                tick();
                if (outs() !== 6'b000010) stray = 1'b1;
            end
            bus.one_second = 1'b1;
            tick();
            bus.one_second = 1'b0;
            if (p == 9) begin
                total++;
                if (outs() !== 6'b000010 || dut.u_timer.timer_q !== 4'd9) begin
                    bad++; $display("FAIL timeout_p9 got=%b/%0d exp=%b/9", outs(), dut.u_timer.timer_q, 6'b000010);
                end
            end
            if (p == 10) begin
                total++;
                if (outs() !== 6'b000010 || dut.u_timer.timer_q !== 4'd10) begin
                    bad++; $display("FAIL timeout_p10 got=%b/%0d exp=%b/10", outs(), dut.u_timer.timer_q, 6'b000010);
                end
            end
        end
        total++;
        if (stray) begin
            bad++; $display("FAIL timeout_wait got=stray_output exp=show_new_time_only");
        end
        tick();
        total++;
        if (outs() !== 6'b000000 || dut.state_q !== SHOW_TIME) begin
            bad++; $display("FAIL timeout_exit got=%b exp=%b", outs(), 6'b000000);
        end
        $display("timeout: entry abandoned after 10 pulses");
    endtask

    task automatic test_show_alarm();
        int shifts;
        shifts = 0;
        for (int i = 0; i < 5; i++) begin
            bus.alarm_button = 1'b1;
            bus.key = (i % 2 == 0) ? 4'd5 : NOKEY;
            tick();
            shifts += int'(bus.shift);
            total++;
            if (outs() !== 6'b000100) begin
                bad++; $display("FAIL show_alarm[%0d] got=%b exp=%b", i, outs(), 6'b000100);
            end
        end
        bus.alarm_button = 1'b0;
        bus.key = NOKEY;
        tick();
        total++;
        if (outs() !== 6'b000000 || shifts != 0) begin
            bad++; $display("FAIL show_alarm_release got=%b shifts=%0d exp=%b shifts=0", outs(), shifts, 6'b000000);
        end
        $display("show_alarm: 5 cycles shown, digits ignored");
    endtask

    task automatic test_priority();
        bus.key = 4'd4; tick();
        bus.key = NOKEY; tick();
        tick();
        bus.one_second = 1'b1; tick();
        // digit and a seconds pulse together: the pulse must not survive into KEY_STORED
        bus.key = 4'd6;
        tick();
        bus.one_second = 1'b0;
        total++;
        if (outs() !== 6'b000011 || dut.u_timer.timer_q !== 4'd0) begin
            bad++; $display("FAIL pulse_on_store got=%b/%0d exp=%b/0", outs(), dut.u_timer.timer_q, 6'b000011);
        end
        bus.key = NOKEY; tick();
        tick();
        bus.alarm_button = 1'b1;
        bus.time_button  = 1'b1;
        bus.key          = 4'd4;
        tick();
        idle_inputs();
        total++;
        if (outs() !== 6'b001000) begin
            bad++; $display("FAIL button_priority got=%b exp=%b", outs(), 6'b001000);
        end
        tick();
        total++;
        if (outs() !== 6'b000000) begin
            bad++; $display("FAIL set_alarm_done got=%b exp=%b", outs(), 6'b000000);
        end
        $display("priority: alarm button beats time button and digit");
    endtask

    task automatic test_back_to_back();
        int shifts;
        shifts = 0;
        bus.key = 4'd8;
        tick();
        total++;
        if (outs() !== 6'b000011) begin
            bad++; $display("FAIL held_store got=%b exp=%b", outs(), 6'b000011);
        end
        tick();
        for (int p = 1; p <= 10; p++) begin
            bus.one_second = 1'b1;
            tick();
            bus.one_second = 1'b0;
            shifts += int'(bus.shift);
            if (p < 10) begin
                tick();
                shifts += int'(bus.shift);
            end
        end
        total++;
        if (outs() !== 6'b000010 || shifts != 0) begin
            bad++; $display("FAIL held_wait got=%b shifts=%0d exp=%b shifts=0", outs(), shifts, 6'b000010);
        end
        tick();
        bus.key = NOKEY;
        total++;
        if (outs() !== 6'b000000 || dut.state_q !== SHOW_TIME) begin
            bad++; $display("FAIL held_timeout got=%b exp=%b", outs(), 6'b000000);
        end
        tick();
        total++;
        if (outs() !== 6'b000000) begin
            bad++; $display("FAIL held_after got=%b exp=%b", outs(), 6'b000000);
        end
        $display("back_to_back: held digit times out without repeat shift");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        test_reset();
        test_shift_sequence();
        test_set_current_time();
        test_timeout();
        test_show_alarm();
        test_priority();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the sequence stalls.
    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
